lsu_mem_ctrl: RTL
=================

// Module: lsu_mem_ctrl
// PURPOSE
//  Load/store sequencer between the core's LSU port and the word-only, sync-read data_mem.
//  Adds byte/halfword loads (sign/zero-extended) and byte/halfword stores (read-modify-write).
//  Reports misaligned, bad-size and out-of-range accesses; only this block drives data_mem.
// PARAMETERS
//  MEM_WORDS   4096   depth of data_mem in 32-bit words; byte addr >= MEM_WORDS*4 is out of range
// PORTS
//  clk_i          in   1   clock, all state on rising edge
//  rst_ni         in   1   asynchronous, active-low reset
//  core_req_i     in   1   access request, held until core_done_o
//  core_we_i      in   1   1=store, 0=load
//  core_size_i    in   3   RISC-V funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
//  core_addr_i    in   32  byte address
//  core_wd_i      in   32  store data, used bits aligned at [7:0]/[15:0]/[31:0]
//  core_rd_o      out  32  load result, valid only when core_done_o=1
//  core_done_o    out  1   one-cycle pulse: access complete
//  core_err_o     out  1   with core_done_o: access rejected, memory untouched
//  core_stall_o   out  1   core_req_i & ~core_done_o
//  mem_req_o      out  1   to data_mem mem_req_i
//  mem_we_o       out  1   to data_mem write_enable_i
//  mem_addr_o     out  32  to data_mem addr_i, always word-aligned ([1:0]=0)
//  mem_wd_o       out  32  to data_mem write_data_i
//  mem_rd_i       in   32  from data_mem read_data_o, valid the cycle after a read
// BEHAVIOUR
//  FSM: IDLE, LOAD_RESP, RMW_WRITE, RESP. Reset -> IDLE; captured addr/size/wd/err regs cleared.
//  Reset outputs: all core_* and mem_* outputs 0 while rst_ni=0.
//  Acceptance: IDLE & core_req_i & rst_ni. Addr, size, wd captured into registers at this edge.
//  Error check at acceptance (combinational on core inputs): size in {011,110,111}; H/HU/SH with
//   addr[0]=1; W with addr[1:0]!=0; addr >= MEM_WORDS*4. On error: no mem access, -> RESP, err=1.
//  Load (any size): IDLE drives mem_req_o=1, we=0, addr={addr[31:2],2'b00} -> LOAD_RESP.
//   LOAD_RESP: done=1; rd = lane selected by captured addr[1:0], sign-ext (B,H) or zero-ext (BU,HU);
//   W passes mem_rd_i unchanged. -> IDLE. Latency: done 1 cycle after acceptance.
//  SW: IDLE drives mem_req_o=1, we=1, wd=core_wd_i -> RESP. RESP: done=1 -> IDLE. Latency 1.
//  SB/SH: IDLE issues read of the word -> RMW_WRITE. RMW_WRITE: mem_req_o=1, we=1,
//   wd = mem_rd_i with target lane(s) replaced by captured wd[7:0]/[15:0] -> RESP. Latency 2.
//  RESP: done=1, err per capture; -> IDLE. rd_o=0 on stores and errors.
//  Mem outputs: 0 in IDLE with no request and in RESP. IDLE outputs combinational from core
//   inputs. LOAD_RESP drives mem_req_o=0. RMW_WRITE drives from captured regs + mem_rd_i.
//  Back-to-back: the core drops or advances core_req_i after done; the next request is accepted
//   in IDLE the following cycle. Throughput: 2 cycles per LW/SW, 3 per SB/SH.
//  core_req_i deasserted mid-access (protocol violation): the access still completes, done still pulses.
//  Reset mid-RMW: state -> IDLE immediately; a pending RMW write is never issued, so memory
//   keeps the old word.
//  No byte enables exist on data_mem. Every sub-word store is a full-word RMW, atomic because
//   this block is the sole master.
// STRUCTURE
//  lsu_pkg: funct3 localparams LDST_B/H/W/BU/HU, state_t enum, size_valid() function.
//  Sub-module lsu_align (combinational):
//   load path: lane extract + sign/zero extend.
//   store path: lane merge of old word and new data.
//  Instantiated once, shared by LOAD_RESP and RMW_WRITE.
// TESTING
//  1. Reset held, core_req_i=1 -> mem_req_o=0, done=0. Release: FSM in IDLE, request accepted.
//  2. SW 0xDEADBEEF @0x10 then LW @0x10 -> write on word 4, done 1 cycle later; LW rd=0xDEADBEEF.
//  3. Word @0x20=0x8081_7F01:
//     LB @0x23 -> 0xFFFFFF80; LBU @0x23 -> 0x00000080; LH @0x22 -> 0xFFFF8081; LHU @0x20 -> 0x00007F01.
//  4. Word @0x30=0x11223344, SB 0xAA @0x31 -> read, then write 0x1122AA44, done 2 cycles after accept;
//     SH 0xBEEF @0x32 -> 0xBEEFAA44.
//  5. LW @0x02, SH @0x05, size=011, LW @0x4000 (MEM_WORDS=4096) -> mem_req_o never 1; done+err next cycle.
//  6. SB @0x30 with rst_ni pulsed low in RMW_WRITE -> no write; then LW @0x30 still returns old word.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the LSU data-memory sequencer.
// funct3 size codes, FSM states and the captured request bundle.
package lsu_pkg;

    localparam logic [2:0] LDST_B  = 3'b000;
    localparam logic [2:0] LDST_H  = 3'b001;
    localparam logic [2:0] LDST_W  = 3'b010;
    localparam logic [2:0] LDST_BU = 3'b100;
    localparam logic [2:0] LDST_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE,
        LOAD_RESP,
        RMW_WRITE,
        RESP
    } state_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [2:0]  size;
        logic [31:0] wd;
        logic        err;
    } lsu_req_t;

    function automatic logic size_valid(input logic [2:0] size);
        return (size == LDST_B)  || (size == LDST_H) ||
               (size == LDST_W)  || (size == LDST_BU) ||
               (size == LDST_HU);
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering between 32-bit memory words and sub-word accesses.
// Load side extracts and extends a lane; store side merges new data.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  size,
    input  logic [1:0]  lane,
    input  logic [31:0] mem_word,
    input  logic [31:0] wd,
    output logic [31:0] ld_data,
    output logic [31:0] st_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_sel = mem_word[{lane, 3'b000} +: 8];
    assign half_sel = lane[1] ? mem_word[31:16] : mem_word[15:0];

    always_comb begin
        ld_data = mem_word;
        unique case (size)
            LDST_B:  ld_data = {{24{byte_sel[7]}}, byte_sel};
            LDST_BU: ld_data = {24'h0, byte_sel};
            LDST_H:  ld_data = {{16{half_sel[15]}}, half_sel};
            LDST_HU: ld_data = {16'h0, half_sel};
            default: ld_data = mem_word;
        endcase
    end

    // Only the addressed lane(s) change; the rest of the old word survives.
    always_comb begin
        st_data = mem_word;
        unique case (size[1:0])
            2'b00: st_data[{lane, 3'b000} +: 8] = wd[7:0];
            2'b01: begin
                if (lane[1]) st_data[31:16] = wd[15:0];
                else         st_data[15:0]  = wd[15:0];
            end
            default: st_data = wd;
        endcase
    end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store sequencer between the core LSU port and a word-only sync-read memory.
// Sub-word stores are performed as read-modify-write; bad accesses never reach memory.
module lsu_mem_ctrl
    import lsu_pkg::*;
#(
    parameter int unsigned MEM_WORDS = 4096
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        core_req_i,
    input  logic        core_we_i,
    input  logic [2:0]  core_size_i,
    input  logic [31:0] core_addr_i,
    input  logic [31:0] core_wd_i,
    output logic [31:0] core_rd_o,
    output logic        core_done_o,
    output logic        core_err_o,
    output logic        core_stall_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wd_o,
    input  logic [31:0] mem_rd_i
);

    localparam logic [31:0] ADDR_LIM = 32'(MEM_WORDS * 4);

    state_t   state_q, state_d;
    lsu_req_t req_q;

    logic        accept;
    logic        req_err;
    logic        is_half;
    logic        is_word;
    logic [31:0] ld_data;
    logic [31:0] st_data;

    assign accept  = (state_q == IDLE) & core_req_i & rst_ni;
    assign is_half = (core_size_i[1:0] == 2'b01);
    assign is_word = (core_size_i == LDST_W);

    assign req_err = !size_valid(core_size_i)
                   | (is_half & core_addr_i[0])
                   | (is_word & (|core_addr_i[1:0]))
                   | (core_addr_i >= ADDR_LIM);

    lsu_align u_align (
        .size     (req_q.size),
        .lane     (req_q.addr[1:0]),
        .mem_word (mem_rd_i),
        .wd       (req_q.wd),
        .ld_data  (ld_data),
        .st_data  (st_data)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            req_q   <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                req_q <= '{addr: core_addr_i,
                           size: core_size_i,
                           wd:   core_wd_i,
                           err:  req_err};
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        core_rd_o   = '0;
        core_done_o = 1'b0;
        core_err_o  = 1'b0;
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wd_o    = '0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (req_err) begin
                        state_d = RESP;
                    end else begin
                        mem_req_o  = 1'b1;
                        mem_addr_o = {core_addr_i[31:2], 2'b00};
                        if (!core_we_i) begin
                            state_d = LOAD_RESP;
                        end else if (core_size_i[1:0] == 2'b10) begin
                            mem_we_o = 1'b1;
                            mem_wd_o = core_wd_i;
                            state_d  = RESP;
                        end else begin
                            state_d = RMW_WRITE;
                        end
                    end
                end
            end
            LOAD_RESP: begin
                core_done_o = 1'b1;
                core_rd_o   = ld_data;
                state_d     = IDLE;
            end
            // Old word arrives this cycle; write back the merged word.
            RMW_WRITE: begin
                mem_req_o  = 1'b1;
                mem_we_o   = 1'b1;
                mem_addr_o = {req_q.addr[31:2], 2'b00};
                mem_wd_o   = st_data;
                state_d    = RESP;
            end
            RESP: begin
                core_done_o = 1'b1;
                core_err_o  = req_q.err;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign core_stall_o = core_req_i & ~core_done_o & rst_ni;

endmodule
